// File: rtl/chip8_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip8_display_pkg
// Purpose  : Shared constants, FSM state encoding and helpers for the CHIP-8
//            framebuffer writer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package chip8_display_pkg;

    localparam int DISP_W = 64;
    localparam int DISP_H = 32;

    localparam logic OP_CLS = 1'b0;
    localparam logic OP_DRW = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VBL = 3'd1,
        CLEAR    = 3'd2,
        FETCH    = 3'd3,
        DRAW     = 3'd4,
        DONE     = 3'd5
    } state_t;

    // First working state once a command is allowed to touch the framebuffer.
    // A zero-height sprite has nothing to fetch and completes immediately.
    function automatic state_t first_work_state(input logic op, input logic [3:0] n);
        if (op == OP_CLS) begin
            return CLEAR;
        end else if (n == 4'd0) begin
            return DONE;
        end else begin
            return FETCH;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_sprite_row.sv
`default_nettype none
// ============================================================================
// Module   : chip8_sprite_row
// Purpose  : Combinational XOR of one 8-pixel sprite byte into a 64-pixel
//            framebuffer row, with collision detection.
// Ports    : i_row          current row contents (bit 63 = leftmost pixel)
//            i_sprite_byte  sprite byte, MSB is the leftmost sprite pixel
//            i_x0           horizontal start position, 0..63
//            o_new_row      row after XOR
//            o_hit          1 when any set sprite pixel lands on a set pixel
// Revision : 1.0 - initial release
// ============================================================================
module chip8_sprite_row
    import chip8_display_pkg::*;
#(
    parameter bit CLIP = 1'b1
) (
    input  logic [DISP_W-1:0] i_row,
    input  logic [7:0]        i_sprite_byte,
    input  logic [5:0]        i_x0,
    output logic [DISP_W-1:0] o_new_row,
    output logic              o_hit
);

    logic [DISP_W-1:0] w_base;
    logic [DISP_W-1:0] w_pattern;

    assign w_base = {i_sprite_byte, {(DISP_W-8){1'b0}}};

    generate
        if (CLIP) begin : g_clip
            // Pixels pushed past the right edge simply fall off.
            assign w_pattern = w_base >> i_x0;
        end else begin : g_wrap
            // Rotate right; a left shift by 64 (x0 = 0) yields zero, so the
            // OR degenerates to the unshifted pattern as required.
            logic [6:0] w_lshift;
            assign w_lshift  = 7'(DISP_W) - {1'b0, i_x0};
            assign w_pattern = (w_base >> i_x0) | (w_base << w_lshift);
        end
    endgenerate

    assign o_new_row = i_row ^ w_pattern;
    assign o_hit     = |(i_row & w_pattern);

endmodule
`default_nettype wire

// File: rtl/chip8_display_writer.sv
`default_nettype none
// ============================================================================
// Module   : chip8_display_writer
// Purpose  : Sole writer of the 64x32 CHIP-8 framebuffer. Executes CLS and
//            DRW (XOR sprite draw with collision), fetching sprite bytes from
//            memory, optionally deferring each command to vertical blank.
// Ports    : clk, rst_n            clock, async active-low reset
//            cmd_valid/cmd_ready   command handshake
//            cmd_op                0 = CLS, 1 = DRW
//            cmd_x, cmd_y, cmd_n   DRW coordinates and sprite height
//            cmd_i                 sprite base address
//            in_vblank             vertical blank flag from VGA generator
//            mem_rd, mem_addr      sprite byte read request
//            mem_rdata             read data, valid 1 cycle after mem_rd
//            done                  one-cycle completion pulse
//            collision             VF result of the last completed DRW
//            display               framebuffer, row 0 on top, bit 63 leftmost
// Revision : 1.0 - initial release
// ============================================================================
module chip8_display_writer
    import chip8_display_pkg::*;
#(
    parameter bit CLIP           = 1'b1,
    parameter bit SYNC_TO_VBLANK = 1'b0,
    parameter int ADDR_W         = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [3:0]        cmd_n,
    input  logic [ADDR_W-1:0] cmd_i,
    input  logic              in_vblank,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              done,
    output logic              collision,
    output logic [DISP_W-1:0] display [0:DISP_H-1]
);

    state_t              r_state;
    state_t              w_state_next;

    logic                r_op;
    logic [5:0]          r_x0;
    logic [4:0]          r_y0;
    logic [3:0]          r_n;
    logic [ADDR_W-1:0]   r_i;
    logic [3:0]          r_row;
    logic                r_acc;
    logic                r_vblank_d;

    logic [5:0]          w_ty_full;
    logic [4:0]          w_ty;
    logic                w_next_clipped;
    logic                w_vbl_rise;
    logic                w_cur_op;
    logic [DISP_W-1:0]   w_cur_row;
    logic [DISP_W-1:0]   w_new_row;
    logic                w_hit;
    logic                w_unused_hi;

    // Starting coordinates always wrap, so the high operand bits are dropped.
    assign w_unused_hi = ^{cmd_x[7:6], cmd_y[7:5]};

    assign w_ty_full  = {1'b0, r_y0} + {2'b00, r_row};
    assign w_ty       = w_ty_full[4:0];
    // With clipping, the row after this one is off-screen once ty reaches 31;
    // deciding here avoids issuing a read for a row that will be discarded.
    assign w_next_clipped = CLIP && (w_ty_full >= 6'd31);
    assign w_vbl_rise = in_vblank & ~r_vblank_d;
    assign w_cur_op   = (r_state == IDLE) ? cmd_op : r_op;
    assign w_cur_row  = display[w_ty];

    chip8_sprite_row #(
        .CLIP (CLIP)
    ) u_sprite_row (
        .i_row         (w_cur_row),
        .i_sprite_byte (mem_rdata),
        .i_x0          (r_x0),
        .o_new_row     (w_new_row),
        .o_hit         (w_hit)
    );

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = SYNC_TO_VBLANK ? WAIT_VBL
                                                  : first_work_state(cmd_op, cmd_n);
                end
            end
            WAIT_VBL: begin
                if (w_vbl_rise) begin
                    w_state_next = first_work_state(r_op, r_n);
                end
            end
            CLEAR: begin
                w_state_next = DONE;
            end
            FETCH: begin
                mem_rd       = 1'b1;
                mem_addr     = r_i + ADDR_W'(r_row);
                w_state_next = DRAW;
            end
            DRAW: begin
                if ((r_row == r_n - 4'd1) || w_next_clipped) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = FETCH;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= OP_CLS;
            r_x0       <= '0;
            r_y0       <= '0;
            r_n        <= '0;
            r_i        <= '0;
            r_row      <= '0;
            r_acc      <= 1'b0;
            r_vblank_d <= 1'b0;
            collision  <= 1'b0;
            for (int r = 0; r < DISP_H; r++) begin
                display[r] <= '0;
            end
        end else begin
            r_state    <= w_state_next;
            r_vblank_d <= in_vblank;

            if (r_state == IDLE && cmd_valid) begin
                r_op  <= cmd_op;
                r_x0  <= cmd_x[5:0];
                r_y0  <= cmd_y[4:0];
                r_n   <= cmd_n;
                r_i   <= cmd_i;
                r_row <= '0;
                r_acc <= 1'b0;
            end

            if (r_state == CLEAR) begin
                for (int r = 0; r < DISP_H; r++) begin
                    display[r] <= '0;
                end
            end

            if (r_state == DRAW) begin
                display[w_ty] <= w_new_row;
                r_acc         <= r_acc | w_hit;
                r_row         <= r_row + 4'd1;
            end

            // Collision is committed on entry to DONE so it is already valid
            // during the done pulse. Zero-height draws report no collision.
            if (w_state_next == DONE && w_cur_op == OP_DRW) begin
                collision <= (r_state == DRAW) ? (r_acc | w_hit) : 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chip8_display_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_chip8_display_writer
// Purpose  : Scoreboard bench for chip8_display_writer. Three instances cover
//            clipping, wrapping and vblank-synchronised operation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip8_display_writer;
    import chip8_display_pkg::*;

    typedef struct packed {
        logic          coll;
        logic [2047:0] img;
        int            reads;
        int            lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_op;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_i;
    logic        in_vblank;
    logic [2:0]  cmd_valid;
    logic [2:0]  cmd_ready;
    logic [2:0]  mem_rd;
    logic [2:0]  done;
    logic [2:0]  coll;
    logic [11:0] mem_addr  [3];
    logic [7:0]  mem_rdata [3];
    logic [63:0] disp0 [0:31];
    logic [63:0] disp1 [0:31];
    logic [63:0] disp2 [0:31];

    logic [7:0]    mem [0:4095];
    logic [2047:0] eimg [3];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc [3];
    int rd_cnt [3];

    always #5 clk = ~clk;

    chip8_display_writer #(.CLIP(1'b1), .SYNC_TO_VBLANK(1'b0), .ADDR_W(12)) u_clip (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .in_vblank(in_vblank), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
        .mem_rdata(mem_rdata[0]), .done(done[0]), .collision(coll[0]), .display(disp0));

    chip8_display_writer #(.CLIP(1'b0), .SYNC_TO_VBLANK(1'b0), .ADDR_W(12)) u_wrap (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .in_vblank(in_vblank), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
        .mem_rdata(mem_rdata[1]), .done(done[1]), .collision(coll[1]), .display(disp1));

    chip8_display_writer #(.CLIP(1'b1), .SYNC_TO_VBLANK(1'b1), .ADDR_W(12)) u_vbl (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .in_vblank(in_vblank), .mem_rd(mem_rd[2]), .mem_addr(mem_addr[2]),
        .mem_rdata(mem_rdata[2]), .done(done[2]), .collision(coll[2]), .display(disp2));

    // Memory: data only on the cycle after a read, junk otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            mem_rdata[k] <= mem_rd[k] ? mem[mem_addr[k]] : 8'hA5;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2047:0] flat(input logic [63:0] d [0:31]);
        logic [2047:0] f;
        for (int r = 0; r < 32; r++) f[r*64 +: 64] = d[r];
        return f;
    endfunction

    function automatic logic [2047:0] img_of(input int k);
        case (k)
            0:       return flat(disp0);
            1:       return flat(disp1);
            default: return flat(disp2);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic cmp_img(input string name, input int k, input logic [2047:0] got,
                           input logic [2047:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            for (int r = 0; r < 32; r++) begin
                if (got[r*64 +: 64] !== want[r*64 +: 64]) begin
                    $display("FAIL %s dut%0d row %0d: got %h want %h", name, k, r,
                             got[r*64 +: 64], want[r*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    task automatic cmp_int(input string name, input int k, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d want %0d", name, k, got, want);
        end
    endtask

    task automatic check_done(input int k);
        exp_t e;
        logic have;
        have = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_done dut%0d: got done=1 want no command outstanding", k);
        end else begin
            cmp_int("collision", k, int'(coll[k]), int'(e.coll));
            cmp_img("display", k, img_of(k), e.img);
            cmp_int("mem_reads", k, rd_cnt[k], e.reads);
            if (e.lat >= 0) cmp_int("latency", k, cyc - acc_cyc[k], e.lat);
        end
        rd_cnt[k] = 0;
    endtask

    // Monitor: counts reads and scores every done pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                rd_cnt[k] = 0;
            end else begin
                if (mem_rd[k]) rd_cnt[k]++;
                if (done[k]) check_done(k);
            end
        end
    end

    task automatic set_row(input int k, input int r, input logic [63:0] v);
        eimg[k][r*64 +: 64] = v;
    endtask

    task automatic issue(input int k, input logic op, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] i, input logic ecoll,
                         input int reads, input int lat, input logic push);
        exp_t e;
        e.coll = ecoll; e.img = eimg[k]; e.reads = reads; e.lat = lat;
        @(negedge clk);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_n = n; cmd_i = i;
        cmd_valid[k] = 1'b1;
        if (push) begin
            case (k)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
        acc_cyc[k] = cyc;
        #1 cmd_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (qsize(k) > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (qsize(k) > 0) begin
            errors++;
            checks++;
            $display("FAIL timeout dut%0d: got %0d outstanding want 0", k, qsize(k));
            case (k)
                0: q0.delete();
                1: q1.delete();
                default: q2.delete();
            endcase
        end
        @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        for (int k = 0; k < 3; k++) begin
            cmp_img(name, k, img_of(k), '0);
            cmp_int({name, "_ready"}, k, int'(cmd_ready[k]), 1);
            cmp_int({name, "_collision"}, k, int'(coll[k]), 0);
            cmp_int({name, "_mem_rd"}, k, int'(mem_rd[k]), 0);
            cmp_int({name, "_mem_addr"}, k, int'(mem_addr[k]), 0);
            cmp_int({name, "_done"}, k, int'(done[k]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[12'h200] = 8'hF0;
        for (int a = 12'h300; a < 12'h304; a++) mem[a] = 8'hFF;
        mem[12'hFFF] = 8'h81;
        mem[12'h000] = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            eimg[k] = '0;
            rd_cnt[k] = 0;
            acc_cyc[k] = 0;
        end
        cmd_valid = '0; cmd_op = OP_CLS; cmd_x = '0; cmd_y = '0; cmd_n = '0; cmd_i = '0;
        in_vblank = 1'b0;

        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        // ---------------- clipping instance ----------------
        set_row(0, 0, 64'hF000_0000_0000_0000);
        issue(0, OP_DRW, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, 1, 3, 1'b1);
        wait_idle(0);
        set_row(0, 0, 64'h0);
        issue(0, OP_DRW, 8'd0, 8'd0, 4'd1, 12'h200, 1'b1, 1, 3, 1'b1);
        wait_idle(0);
        // CLS leaves collision alone
        issue(0, OP_CLS, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1, 0, 2, 1'b1);
        wait_idle(0);
        // zero-height draw clears collision, no reads
        issue(0, OP_DRW, 8'd5, 8'd5, 4'd0, 12'h200, 1'b0, 0, 1, 1'b1);
        wait_idle(0);
        set_row(0, 30, 64'h0000_0000_0000_000F);
        set_row(0, 31, 64'h0000_0000_0000_000F);
        issue(0, OP_DRW, 8'd60, 8'd30, 4'd4, 12'h300, 1'b0, 2, -1, 1'b1);
        wait_idle(0);
        // address wraps from 0xFFF to 0x000
        set_row(0, 5, 64'h0081_0000_0000_0000);
        set_row(0, 6, 64'h003C_0000_0000_0000);
        issue(0, OP_DRW, 8'd8, 8'd5, 4'd2, 12'hFFF, 1'b0, 2, 5, 1'b1);
        wait_idle(0);
        set_row(0, 5, 64'h008E_0000_0000_0000);
        issue(0, OP_DRW, 8'd12, 8'd5, 4'd1, 12'h200, 1'b1, 1, 3, 1'b1);
        wait_idle(0);

        // ---------------- wrapping instance ----------------
        set_row(1, 30, 64'hF000_0000_0000_000F);
        set_row(1, 31, 64'hF000_0000_0000_000F);
        set_row(1, 0,  64'hF000_0000_0000_000F);
        set_row(1, 1,  64'hF000_0000_0000_000F);
        issue(1, OP_DRW, 8'd60, 8'd30, 4'd4, 12'h300, 1'b0, 4, 9, 1'b1);
        wait_idle(1);
        set_row(1, 3, 64'h03C0_0000_0000_0000);
        issue(1, OP_DRW, 8'd70, 8'd35, 4'd1, 12'h200, 1'b0, 1, 3, 1'b1);
        wait_idle(1);
        set_row(1, 30, 64'h0);
        set_row(1, 31, 64'h0);
        set_row(1, 0,  64'h0);
        set_row(1, 1,  64'h0);
        issue(1, OP_DRW, 8'd60, 8'd30, 4'd4, 12'h300, 1'b1, 4, 9, 1'b1);
        wait_idle(1);

        // ---------------- vblank instance ----------------
        // Already inside vblank at accept: must wait for the next rising edge.
        @(negedge clk);
        in_vblank = 1'b1;
        set_row(2, 10, 64'hF000_0000_0000_0000);
        issue(2, OP_DRW, 8'd0, 8'd10, 4'd1, 12'h200, 1'b0, 1, -1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            cmd_op = OP_CLS;
            cmd_valid[2] = 1'b1;
        end
        @(negedge clk);
        cmd_valid[2] = 1'b0;
        cmp_img("vbl_hold_in_blank", 2, img_of(2), '0);
        in_vblank = 1'b0;
        repeat (3) @(negedge clk);
        cmp_img("vbl_hold_active", 2, img_of(2), '0);
        in_vblank = 1'b1;
        @(negedge clk);
        cmp_img("vbl_hold_rise", 2, img_of(2), '0);
        wait_idle(2);
        repeat (10) @(negedge clk);
        in_vblank = 1'b0;

        // ---------------- reset mid-command ----------------
        issue(0, OP_DRW, 8'd0, 8'd20, 4'd3, 12'h300, 1'b0, 0, -1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cmp_int("reads_before_reset", 0, rd_cnt[0], 2);
        checks++;
        if (disp0[20] !== 64'hFF00_0000_0000_0000) begin
            errors++;
            $display("FAIL row20_before_reset dut0: got %h want %h", disp0[20],
                     64'hFF00_0000_0000_0000);
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) eimg[k] = '0;
        check_reset("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        cmp_int("reads_after_reset", 0, rd_cnt[0], 0);
        cmp_int("ready_after_reset", 0, int'(cmd_ready[0]), 1);
        cmp_img("display_after_reset", 0, img_of(0), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
